// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - per-PE sequencer for conv (N MACs + bias) and max-pool jobs
module pe_seq_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] elem_count,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       pe_resp,
    output logic             actn_in_sel,
    output logic             wt_in_sel,
    output logic             add_in_sel,
    output logic             pe_out_sel,
    output logic             if_rf_wr_en,
    output logic             wt_rf_wr_en,
    output logic             of_rf_wr_en,
    output logic             mult_en,
    output logic             mult_load,
    output logic             add_en,
    output logic             acc_wr_en,
    output logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_LOAD, S_MLD, S_MUL, S_ADD, S_ACCW,
        S_BLOAD, S_BADD, S_BACCW, S_OUTW, S_ERR
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, n_lat, n_d;
    logic             mode_lat, mode_d;
    logic [WD_W-1:0]  wd, wd_d;
    logic             if_arm, if_arm_d, wt_arm, wt_arm_d;

    logic             in_ready_d, actn_in_sel_d, wt_in_sel_d, add_in_sel_d, pe_out_sel_d;
    logic             of_rf_wr_en_d, mult_en_d, mult_load_d, add_en_d, acc_wr_en_d;
    logic             acc_clr_d, busy_d, done_d, err_d;

    logic             hs, wd_hit, waiting_d;
    logic [CNT_W-1:0] cnt_inc;

    // Regfile writes must land in the handshake cycle, so the registered arm is qualified by in_valid.
    assign if_rf_wr_en = if_arm & in_valid;
    assign wt_rf_wr_en = wt_arm & in_valid;

    assign hs      = in_ready & in_valid;
    assign wd_hit  = (wd == WD_LAST);
    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        n_d     = n_lat;
        mode_d  = mode_lat;
        err_d   = err;
        done_d  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    n_d    = elem_count;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (!mode)
                        state_d = S_CLR;
                    else if (elem_count == '0)
                        state_d = S_OUTW;
                    else
                        state_d = S_LOAD;
                end
            end
            S_CLR:   state_d = (n_lat != '0) ? S_LOAD : S_BLOAD;
            S_LOAD: begin
                if (hs) begin
                    cnt_d = cnt_inc;
                    if (!mode_lat)
                        state_d = S_MLD;
                    else if (cnt_inc == n_lat)
                        state_d = S_OUTW;
                end
            end
            S_MLD:   state_d = S_MUL;
            S_MUL: begin
                if (pe_resp[0])
                    state_d = S_ADD;
                else if (wd_hit)
                    state_d = S_ERR;
            end
            S_ADD: begin
                if (pe_resp[1])
                    state_d = S_ACCW;
                else if (wd_hit)
                    state_d = S_ERR;
            end
            S_ACCW:  state_d = (cnt < n_lat) ? S_LOAD : S_BLOAD;
            S_BLOAD: if (hs) state_d = S_BADD;
            S_BADD: begin
                if (pe_resp[1])
                    state_d = S_BACCW;
                else if (wd_hit)
                    state_d = S_ERR;
            end
            S_BACCW: state_d = S_OUTW;
            S_OUTW: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a start seen in IDLE.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = cnt;
            n_d     = n_lat;
            mode_d  = mode_lat;
            err_d   = err;
            done_d  = 1'b0;
        end

        if (state_d == S_ERR)
            err_d = 1'b1;

        waiting_d = (state_d == S_MUL) || (state_d == S_ADD) || (state_d == S_BADD);
        wd_d      = (waiting_d && state_d == state) ? wd + WD_W'(1) : '0;

        // Moore outputs are decoded from the next state and registered alongside it.
        in_ready_d    = (state_d == S_LOAD) || (state_d == S_BLOAD);
        if_arm_d      = (state_d == S_LOAD);
        wt_arm_d      = ((state_d == S_LOAD) && !mode_d) || (state_d == S_BLOAD);
        acc_clr_d     = (state_d == S_CLR);
        mult_load_d   = (state_d == S_MLD);
        mult_en_d     = (state_d == S_MUL);
        add_en_d      = (state_d == S_ADD) || (state_d == S_BADD);
        acc_wr_en_d   = (state_d == S_ACCW) || (state_d == S_BACCW);
        of_rf_wr_en_d = (state_d == S_OUTW);
        busy_d        = (state_d != S_IDLE);

        actn_in_sel_d = actn_in_sel;
        wt_in_sel_d   = wt_in_sel;
        add_in_sel_d  = add_in_sel;
        pe_out_sel_d  = pe_out_sel;
        case (state_d)
            S_LOAD: begin
                actn_in_sel_d = !mode_d;
                if (!mode_d)
                    wt_in_sel_d = 1'b1;
            end
            S_BLOAD: wt_in_sel_d  = 1'b0;
            S_ADD:   add_in_sel_d = 1'b0;
            S_BADD:  add_in_sel_d = 1'b1;
            S_OUTW:  pe_out_sel_d = mode_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            n_lat       <= '0;
            mode_lat    <= 1'b0;
            wd          <= '0;
            if_arm      <= 1'b0;
            wt_arm      <= 1'b0;
            in_ready    <= 1'b0;
            actn_in_sel <= 1'b1;
            wt_in_sel   <= 1'b1;
            add_in_sel  <= 1'b0;
            pe_out_sel  <= 1'b0;
            of_rf_wr_en <= 1'b0;
            mult_en     <= 1'b0;
            mult_load   <= 1'b0;
            add_en      <= 1'b0;
            acc_wr_en   <= 1'b0;
            acc_clr     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            n_lat       <= n_d;
            mode_lat    <= mode_d;
            wd          <= wd_d;
            if_arm      <= if_arm_d;
            wt_arm      <= wt_arm_d;
            in_ready    <= in_ready_d;
            actn_in_sel <= actn_in_sel_d;
            wt_in_sel   <= wt_in_sel_d;
            add_in_sel  <= add_in_sel_d;
            pe_out_sel  <= pe_out_sel_d;
            of_rf_wr_en <= of_rf_wr_en_d;
            mult_en     <= mult_en_d;
            mult_load   <= mult_load_d;
            add_en      <= add_en_d;
            acc_wr_en   <= acc_wr_en_d;
            acc_clr     <= acc_clr_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - randomized self-checking bench for pe_seq_ctrl
module tb_pe_seq_ctrl;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, mode, abort, in_valid;
    logic [CNT_W-1:0] elem_count;
    logic [1:0]       pe_resp;
    logic             in_ready, actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel;
    logic             if_rf_wr_en, wt_rf_wr_en, of_rf_wr_en, mult_en, mult_load;
    logic             add_en, acc_wr_en, acc_clr, busy, done, err;

    always #5 clk = ~clk;

    pe_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .elem_count(elem_count),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .pe_resp(pe_resp),
        .actn_in_sel(actn_in_sel), .wt_in_sel(wt_in_sel), .add_in_sel(add_in_sel),
        .pe_out_sel(pe_out_sel), .if_rf_wr_en(if_rf_wr_en), .wt_rf_wr_en(wt_rf_wr_en),
        .of_rf_wr_en(of_rf_wr_en), .mult_en(mult_en), .mult_load(mult_load),
        .add_en(add_en), .acc_wr_en(acc_wr_en), .acc_clr(acc_clr), .busy(busy),
        .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] out_vec();
        return {in_ready, actn_in_sel, wt_in_sel, add_in_sel, pe_out_sel, if_rf_wr_en,
                wt_rf_wr_en, of_rf_wr_en, mult_en, mult_load, add_en, acc_wr_en,
                acc_clr, busy, done, err};
    endfunction

    localparam logic [15:0] RESET_VEC = 16'h6000;
    localparam logic [15:0] ENA_MASK  = 16'h87FE;

    int n_if, n_wt, n_wt1, n_ml, n_me, n_ae, n_acc, n_clr, n_of, n_done;
    int n_add0, n_add1, bad_sel, bad_rdy, done_bad, n_hs;
    bit last_wt_sel, of_sel, first_err, prev_of, prev_add;

    // stop: 0 run to done, 1 stop at first add_en, 2 stop at first mult_en, 3 stop when err seen
    task automatic run_job(input string tag, input bit m, input int n, input int mdly,
                           input int adly, input int vmode, input int stop,
                           input bit no_resp0, input bit noise);
        int mc, ac;
        bit tgl, finished;
        n_if = 0; n_wt = 0; n_wt1 = 0; n_ml = 0; n_me = 0; n_ae = 0; n_acc = 0;
        n_clr = 0; n_of = 0; n_done = 0; n_add0 = 0; n_add1 = 0; bad_sel = 0;
        bad_rdy = 0; done_bad = 0; n_hs = 0; last_wt_sel = 1'b1; of_sel = 1'b0;
        prev_of = 1'b0; prev_add = 1'b0; first_err = 1'b1;
        mc = 0; ac = 0; tgl = 1'b1; finished = 1'b0;
        @(negedge clk);
        mode = m; elem_count = n[CNT_W-1:0]; start = 1'b1;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            start = 1'b0;
            pe_resp[0] = (mc > 0) ? (!no_resp0 && mc >= mdly)
                                  : (noise && !no_resp0 && $urandom_range(0, 7) == 0);
            pe_resp[1] = (ac > 0) ? (ac >= adly) : (noise && $urandom_range(0, 7) == 0);
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tgl : 1'($urandom_range(0, 1));
            tgl = !tgl;
            #1;
            if (c == 0) first_err = err;
            if (in_ready && in_valid) n_hs++;
            if (if_rf_wr_en) begin
                n_if++;
                if (actn_in_sel !== !m) bad_sel++;
            end
            if (wt_rf_wr_en) begin
                n_wt++;
                if (wt_in_sel) n_wt1++;
                last_wt_sel = wt_in_sel;
            end
            n_ml  += int'(mult_load);
            n_me  += int'(mult_en);
            n_ae  += int'(add_en);
            n_clr += int'(acc_clr);
            n_acc += int'(acc_wr_en);
            if (add_en && !prev_add) begin
                if (add_in_sel) n_add1++; else n_add0++;
            end
            if (of_rf_wr_en) begin
                n_of++;
                of_sel = pe_out_sel;
            end
            if (done) begin
                n_done++;
                if (!prev_of) done_bad++;
                if (stop == 0) finished = 1'b1;
            end
            if (in_ready && !busy) bad_rdy++;
            prev_of  = of_rf_wr_en;
            prev_add = add_en;
            if ((stop == 1 && add_en) || (stop == 2 && mult_en) || (stop == 3 && err))
                finished = 1'b1;
            mc = mult_en ? mc + 1 : 0;
            ac = add_en ? ac + 1 : 0;
        end
        pe_resp  = 2'b00;
        in_valid = 1'b0;
        check({tag, "_reached_end"}, 32'(finished), 32'd1);
    endtask

    // Expected activity of a complete job, from the job description alone.
    task automatic check_job(input string tag, input bit m, input int n, input int mdly,
                             input int adly, input bit timing);
        check({tag, "_if_wr"},  n_if,  n);
        check({tag, "_wt_wr"},  n_wt,  m ? 0 : n + 1);
        check({tag, "_hs"},     n_hs,  m ? n : n + 1);
        check({tag, "_mload"},  n_ml,  m ? 0 : n);
        check({tag, "_acc_wr"}, n_acc, m ? 0 : n + 1);
        check({tag, "_acc_clr"}, n_clr, m ? 0 : 1);
        check({tag, "_of_wr"},  n_of,  1);
        check({tag, "_out_sel"}, 32'(of_sel), 32'(m));
        check({tag, "_done"},   n_done, 1);
        check({tag, "_done_after_of"}, done_bad, 0);
        check({tag, "_actn_sel"}, bad_sel, 0);
        check({tag, "_rdy_idle"}, bad_rdy, 0);
        check({tag, "_first_err"}, 32'(first_err), 0);
        if (m) begin
            check({tag, "_mult_cyc"}, n_me, 0);
            check({tag, "_add_cyc"},  n_ae, 0);
        end else begin
            check({tag, "_wt_sel1"},  n_wt1, n);
            check({tag, "_bias_sel"}, 32'(last_wt_sel), 0);
            check({tag, "_add_prod"}, n_add0, n);
            check({tag, "_add_bias"}, n_add1, 1);
            if (n == 0)
                check({tag, "_no_mult"}, n_me, 0);
            if (timing) begin
                check({tag, "_mult_cyc"}, n_me, n * (mdly + 1));
                check({tag, "_add_cyc"},  n_ae, (n + 1) * (adly + 1));
            end
        end
    endtask

    initial begin
        bit rm;
        int rn, rmd, rad;
        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; in_valid = 1'b0;
        pe_resp = 2'b00; elem_count = '0;
        #2;
        check("reset_async", 32'(out_vec()), 32'(RESET_VEC));
        @(negedge clk);
        @(negedge clk);
        check("reset_vec", 32'(out_vec()), 32'(RESET_VEC));
        rst = 1'b0;

        run_job("conv3", 1'b0, 3, 4, 4, 0, 0, 1'b0, 1'b0);
        check_job("conv3", 1'b0, 3, 4, 4, 1'b1);
        run_job("conv0", 1'b0, 0, 4, 4, 0, 0, 1'b0, 1'b0);
        check_job("conv0", 1'b0, 0, 4, 4, 1'b1);
        run_job("pool4", 1'b1, 4, 1, 1, 1, 0, 1'b0, 1'b0);
        check_job("pool4", 1'b1, 4, 1, 1, 1'b0);
        check("pool4_wt_idle", 32'(wt_in_sel), 32'd0);
        run_job("pool0", 1'b1, 0, 1, 1, 2, 0, 1'b0, 1'b0);
        check_job("pool0", 1'b1, 0, 1, 1, 1'b0);
        run_job("pool255", 1'b1, 255, 1, 1, 2, 0, 1'b0, 1'b1);
        check_job("pool255", 1'b1, 255, 1, 1, 1'b0);

        for (int j = 0; j < 20; j++) begin
            rm  = 1'($urandom_range(0, 1));
            rn  = $urandom_range(0, 5);
            rmd = $urandom_range(1, 4);
            rad = $urandom_range(1, 4);
            run_job("rand", rm, rn, rmd, rad, 2, 0, 1'b0, 1'b1);
            check_job("rand", rm, rn, rmd, rad, 1'b0);
        end

        // Watchdog: multiplier never answers.
        run_job("tmo", 1'b0, 1, 1, 1, 0, 3, 1'b1, 1'b0);
        check("tmo_mul_cycles", n_me, TIMEOUT);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_enables", 32'(out_vec() & 16'h87F8), 32'd0);
        @(negedge clk); #1;
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_err_sticky", 32'(err), 32'd1);
        run_job("after_tmo", 1'b0, 1, 2, 2, 0, 0, 1'b0, 1'b0);
        check_job("after_tmo", 1'b0, 1, 2, 2, 1'b1);

        // Abort in ADD with a simultaneous start.
        run_job("abort", 1'b0, 2, 2, 6, 0, 1, 1'b0, 1'b0);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        check("abort_enables", 32'(out_vec() & ENA_MASK), 32'd0);
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            n_done += int'(done) + int'(busy);
        end
        check("abort_no_done", n_done, 0);

        // Abort beats start in IDLE.
        @(negedge clk);
        abort = 1'b1; start = 1'b1; mode = 1'b0; elem_count = 8'd2;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of MUL.
        run_job("rstmul", 1'b0, 2, 8, 2, 0, 2, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_midjob", 32'(out_vec()), 32'(RESET_VEC));
        @(negedge clk);
        rst = 1'b0;
        run_job("post_rst", 1'b0, 2, 3, 2, 0, 0, 1'b0, 1'b0);
        check_job("post_rst", 1'b0, 2, 3, 2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
